// File: rtl/ktms_debug_trace.sv
// Debug trace block: snapshot registers plus per-channel capture rings, readable
// through a fixed-latency MMIO window, with a control register and an error-inject register.
module ktms_debug_trace #(
   parameter int regs             = 16,
   parameter int channels         = 2,
   parameter int cr_depth         = 16,
   parameter int mmioaddr         = 1,
   parameter int mmioaddr_ctl     = 2,
   parameter int mmioaddr_err_inj = 3,
   parameter int mmiobus_width    = 94
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [mmiobus_width-1:0]     i_mmiobus,
   input  logic [64*regs-1:0]           i_dbg_reg,
   input  logic [channels-1:0]          i_cap_v,
   input  logic [128*channels-1:0]      i_cap_d,
   output logic                         o_mmio_rd_v,
   output logic [63:0]                  o_mmio_rd_d,
   output logic [63:0]                  o_errinj,
   output logic [channels-1:0]          o_frozen
);

   localparam int PTR_W  = $clog2(cr_depth);
   localparam int CNT_W  = PTR_W + 1;
   localparam int MAP_SZ = regs + channels * (1 + 2 * cr_depth);
   localparam int LOFF_W = $clog2(MAP_SZ);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(cr_depth);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } state_t;

   // Bus layout {vld,cfg,rnw,dw,addr[0:24],data[0:64]}; addr[24] and data parity (bit 0) are ignored.
   logic        bus_vld, bus_cfg, bus_rnw, bus_dw;
   logic [23:0] bus_addr;
   logic [63:0] bus_data;
   logic        unused_bus;

   assign bus_vld    = i_mmiobus[93];
   assign bus_cfg    = i_mmiobus[92];
   assign bus_rnw    = i_mmiobus[91];
   assign bus_dw     = i_mmiobus[90];
   assign bus_addr   = i_mmiobus[89:66];
   assign bus_data   = i_mmiobus[64:1];
   assign unused_bus = ^{i_mmiobus[65], i_mmiobus[0]};

   // Reset: asserts asynchronously, releases two clocks after reset rises.
   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rst_n;

   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign rst_n      = rst_sync_q[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync_q <= '0;
      else        rst_sync_q <= rst_sync_d;
   end

   // The read window is a naturally aligned power-of-two block; mmioaddr selects which block.
   logic              base_ok, win_sel, rd_hit, ctl_wr, ei_wr;
   logic [LOFF_W-1:0] rd_off;

   assign base_ok = bus_vld && !bus_cfg && bus_dw;
   assign win_sel = (bus_addr[23:LOFF_W] == (24-LOFF_W)'(mmioaddr));
   assign rd_hit  = base_ok && bus_rnw && win_sel;
   assign ctl_wr  = base_ok && !bus_rnw && !win_sel && (bus_addr == 24'(mmioaddr_ctl));
   assign ei_wr   = base_ok && !bus_rnw && !win_sel && (bus_addr == 24'(mmioaddr_err_inj));
   assign rd_off  = bus_addr[LOFF_W-1:0];

   logic [63:0]      dbg_q [regs];
   logic [63:0]      dbg_d [regs];
   logic [127:0]     ent_q [channels][cr_depth];
   logic [127:0]     ent_d [channels][cr_depth];
   state_t           state_q [channels];
   state_t           state_d [channels];
   logic [PTR_W-1:0] wrptr_q [channels];
   logic [PTR_W-1:0] wrptr_d [channels];
   logic [CNT_W-1:0] count_q [channels];
   logic [CNT_W-1:0] count_d [channels];
   logic             mode_q, mode_d;
   logic [63:0]      errinj_q, errinj_d;
   logic             rd1_v_q, rd1_v_d, rd2_v_q, rd2_v_d;
   logic [63:0]      rd1_d_q, rd1_d_d, rd2_d_q, rd2_d_d;
   logic [63:0]      status [channels];
   logic [63:0]      rd_mux;
   logic [31:0]      off;

   always_comb begin
      for (int r = 0; r < regs; r++) dbg_d[r] = i_dbg_reg[64*r +: 64];
   end

   // Channel control: captures are judged against the current state, control writes take effect next cycle.
   always_comb begin
      ent_d    = ent_q;
      state_d  = state_q;
      wrptr_d  = wrptr_q;
      count_d  = count_q;
      mode_d   = ctl_wr ? bus_data[1] : mode_q;
      errinj_d = ei_wr ? bus_data : errinj_q;
      for (int c = 0; c < channels; c++) begin
         if (ctl_wr && bus_data[0]) begin
            wrptr_d[c] = '0;
            count_d[c] = '0;
         end else if (state_q[c] == ST_RUN && i_cap_v[c]) begin
            ent_d[c][wrptr_q[c]] = i_cap_d[128*c +: 128];
            wrptr_d[c]           = wrptr_q[c] + PTR_W'(1);
            if (count_q[c] != DEPTH_CNT) count_d[c] = count_q[c] + CNT_W'(1);
         end
         case (state_q[c])
            ST_IDLE: if (ctl_wr && bus_data[63-c]) state_d[c] = ST_RUN;
            ST_RUN: begin
               if (ctl_wr && !bus_data[63-c])              state_d[c] = ST_IDLE;
               else if (mode_q && count_d[c] == DEPTH_CNT) state_d[c] = ST_STOP;
            end
            ST_STOP: begin
               if (ctl_wr && bus_data[0]) state_d[c] = bus_data[63-c] ? ST_RUN : ST_IDLE;
            end
            default: state_d[c] = ST_IDLE;
         endcase
      end
   end

   // Read data is picked from pre-update storage in the request cycle, then staged twice.
   always_comb begin
      rd_mux = '0;
      off    = 32'(rd_off);
      for (int c = 0; c < channels; c++) begin
         status[c]        = '0;
         status[c][63:56] = 8'(wrptr_q[c]);
         status[c][55:48] = 8'(count_q[c]);
         status[c][47:46] = state_q[c];
      end
      for (int r = 0; r < regs; r++) begin
         if (off == 32'(r)) rd_mux = dbg_q[r];
      end
      for (int c = 0; c < channels; c++) begin
         if (off == 32'(regs + c*(1 + 2*cr_depth))) rd_mux = status[c];
         for (int s = 0; s < cr_depth; s++) begin
            if (off == 32'(regs + c*(1 + 2*cr_depth) + 1 + 2*s)) rd_mux = ent_q[c][s][127:64];
            if (off == 32'(regs + c*(1 + 2*cr_depth) + 2 + 2*s)) rd_mux = ent_q[c][s][63:0];
         end
      end
      rd1_v_d = rd_hit;
      rd1_d_d = rd_hit ? rd_mux : '0;
      rd2_v_d = rd1_v_q;
      rd2_d_d = rd1_v_q ? rd1_d_q : '0;
   end

   always_ff @(posedge clk) begin
      dbg_q <= dbg_d;
      ent_q <= ent_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= '{default: ST_IDLE};
         wrptr_q  <= '{default: '0};
         count_q  <= '{default: '0};
         mode_q   <= 1'b0;
         errinj_q <= '0;
         rd1_v_q  <= 1'b0;
         rd1_d_q  <= '0;
         rd2_v_q  <= 1'b0;
         rd2_d_q  <= '0;
      end else begin
         state_q  <= state_d;
         wrptr_q  <= wrptr_d;
         count_q  <= count_d;
         mode_q   <= mode_d;
         errinj_q <= errinj_d;
         rd1_v_q  <= rd1_v_d;
         rd1_d_q  <= rd1_d_d;
         rd2_v_q  <= rd2_v_d;
         rd2_d_q  <= rd2_d_d;
      end
   end

   always_comb begin
      for (int c = 0; c < channels; c++) o_frozen[c] = (state_q[c] == ST_STOP);
   end

   assign o_mmio_rd_v = rd2_v_q;
   assign o_mmio_rd_d = rd2_d_q;
   assign o_errinj    = errinj_q;

endmodule

// File: tb/tb_ktms_debug_trace.sv
// Directed bench for ktms_debug_trace: snapshot reads, wrap/stop capture, collisions,
// error injection and reset during an outstanding read.
module tb_ktms_debug_trace;

   localparam int REGS  = 16;
   localparam int CH    = 2;
   // 82-dword map lives in the 128-dword aligned block number 1.
   localparam logic [23:0] WIN    = 24'd128;
   localparam logic [23:0] A_CTL  = 24'd2;
   localparam logic [23:0] A_EI   = 24'd3;
   localparam logic [23:0] ST0    = WIN + 24'd16;
   localparam logic [23:0] ST1    = WIN + 24'd49;
   localparam logic [23:0] E0     = WIN + 24'd17;
   localparam logic [23:0] E1     = WIN + 24'd50;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [93:0]          i_mmiobus;
   logic [64*REGS-1:0]   i_dbg_reg;
   logic [CH-1:0]        i_cap_v;
   logic [128*CH-1:0]    i_cap_d;
   logic                 o_mmio_rd_v;
   logic [63:0]          o_mmio_rd_d;
   logic [63:0]          o_errinj;
   logic [CH-1:0]        o_frozen;

   int total = 0;
   int bad   = 0;
   logic [63:0] d;

   always #5 clk = ~clk;

   ktms_debug_trace dut (
      .clk         (clk),
      .reset       (reset),
      .i_mmiobus   (i_mmiobus),
      .i_dbg_reg   (i_dbg_reg),
      .i_cap_v     (i_cap_v),
      .i_cap_d     (i_cap_d),
      .o_mmio_rd_v (o_mmio_rd_v),
      .o_mmio_rd_d (o_mmio_rd_d),
      .o_errinj    (o_errinj),
      .o_frozen    (o_frozen)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [93:0] bus(input logic vld, input logic cfg, input logic rnw,
                                       input logic dw, input logic [23:0] a, input logic [63:0] dat);
      return {vld, cfg, rnw, dw, a, 1'b0, dat, 1'b0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cap(input int ch, input logic [63:0] a, input logic [63:0] b);
      i_cap_v[ch]            = 1'b1;
      i_cap_d[128*ch +: 128] = {a, b};
   endtask

   task automatic cap(input int ch, input logic [63:0] a, input logic [63:0] b);
      set_cap(ch, a, b);
      tick();
      i_cap_v = '0;
   endtask

   task automatic raw(input logic [93:0] v);
      i_mmiobus = v;
      tick();
      i_mmiobus = '0;
      i_cap_v   = '0;
   endtask

   task automatic wr(input logic [23:0] a, input logic [63:0] dat);
      raw(bus(1'b1, 1'b0, 1'b0, 1'b1, a, dat));
   endtask

   task automatic rd(input logic [23:0] a, output logic [63:0] dat);
      raw(bus(1'b1, 1'b0, 1'b1, 1'b1, a, 64'h0));
      check("rd_v_n1", 64'(o_mmio_rd_v), 64'h0);
      tick();
      check("rd_v_n2", 64'(o_mmio_rd_v), 64'h1);
      dat = o_mmio_rd_d;
      tick();
      check("rd_v_n3", 64'(o_mmio_rd_v), 64'h0);
   endtask

   initial begin
      reset     = 1'b0;
      i_mmiobus = '0;
      i_cap_v   = '0;
      i_cap_d   = '0;
      for (int r = 0; r < REGS; r++) i_dbg_reg[64*r +: 64] = 64'hA5A5_0000_0000_0000 | 64'(r);
      i_dbg_reg[64*3 +: 64] = 64'hDEAD_BEEF_0000_0003;
      repeat (3) tick();
      check("rst_rd_v", 64'(o_mmio_rd_v), 64'h0);
      check("rst_rd_d", o_mmio_rd_d, 64'h0);
      check("rst_errinj", o_errinj, 64'h0);
      check("rst_frozen", 64'(o_frozen), 64'h0);
      reset = 1'b1;
      repeat (4) tick();

      // snapshot reads and map edges
      rd(WIN + 24'd3, d);   check("snap3", d, 64'hDEAD_BEEF_0000_0003);
      rd(WIN, d);           check("snap0", d, 64'hA5A5_0000_0000_0000);
      rd(WIN + 24'd15, d);  check("snap15", d, 64'hA5A5_0000_0000_000F);
      rd(WIN + 24'd90, d);  check("out_of_map", d, 64'h0);
      rd(ST0, d);           check("st0_reset", d, 64'h0);
      i_dbg_reg[64*3 +: 64] = 64'h0000_0000_0000_1234;
      tick();
      rd(WIN + 24'd3, d);   check("snap3_upd", d, 64'h1234);

      // wrap mode, 18 captures; ch1 captures while idle are dropped
      wr(A_CTL, 64'h8000_0000_0000_0000);
      for (int k = 0; k < 18; k++) begin
         set_cap(0, 64'(k), 64'(k + 100));
         if (k == 5) set_cap(1, 64'hFFFF, 64'h1);
         tick();
         i_cap_v = '0;
      end
      rd(ST0, d);           check("wrap_status", d, 64'h0210_4000_0000_0000);
      rd(E0, d);            check("wrap_s0a", d, 64'd16);
      rd(E0 + 24'd1, d);    check("wrap_s0b", d, 64'd116);
      rd(E0 + 24'd2, d);    check("wrap_s1a", d, 64'd17);
      rd(E0 + 24'd4, d);    check("wrap_s2a", d, 64'd2);
      rd(ST1, d);           check("ch1_idle", d, 64'h0);
      check("wrap_frozen", 64'(o_frozen), 64'h0);

      // stop mode, clear keeps entries
      wr(A_CTL, 64'h8000_0000_0000_0003);
      rd(ST0, d);           check("clr_status", d, 64'h0000_4000_0000_0000);
      rd(E0, d);            check("clr_keeps_ent", d, 64'd16);
      for (int k = 0; k < 20; k++) begin
         cap(0, 64'(k), 64'(k + 100));
         if (k == 14) check("frozen_15", 64'(o_frozen), 64'h0);
         if (k == 15) check("frozen_16", 64'(o_frozen), 64'h1);
      end
      check("frozen_20", 64'(o_frozen), 64'h1);
      rd(ST0, d);           check("stop_status", d, 64'h0010_8000_0000_0000);
      rd(E0, d);            check("stop_s0a", d, 64'd0);
      rd(E0 + 24'd30, d);   check("stop_s15a", d, 64'd15);
      wr(A_CTL, 64'h8000_0000_0000_0003);
      check("restart_frozen", 64'(o_frozen), 64'h0);
      rd(ST0, d);           check("restart_status", d, 64'h0000_4000_0000_0000);

      // clear coincident with capture
      for (int k = 0; k < 3; k++) cap(0, 64'h300 + 64'(k), 64'h0);
      set_cap(0, 64'hBAD, 64'h0);
      wr(A_CTL, 64'h8000_0000_0000_0001);
      rd(ST0, d);           check("coll_status", d, 64'h0000_4000_0000_0000);
      rd(E0 + 24'd6, d);    check("coll_s3a", d, 64'd3);
      rd(E0, d);            check("coll_s0a", d, 64'h300);

      // disable coincident with capture: capture kept, then idle
      set_cap(0, 64'h77, 64'h0);
      wr(A_CTL, 64'h0);
      rd(ST0, d);           check("dis_status", d, 64'h0101_0000_0000_0000);
      rd(E0, d);            check("dis_s0a", d, 64'h77);
      cap(0, 64'h88, 64'h0);
      rd(ST0, d);           check("idle_drop_st", d, 64'h0101_0000_0000_0000);
      rd(E0 + 24'd2, d);    check("idle_drop_s1a", d, 64'h301);

      // read and capture of the same slot
      wr(A_CTL, 64'h4000_0000_0000_0000);
      for (int k = 0; k < 16; k++) cap(1, 64'h1000 + 64'(k), 64'h0);
      set_cap(1, 64'h9999, 64'h0);
      rd(E1, d);            check("rdcap_old", d, 64'h1000);
      rd(E1, d);            check("rdcap_new", d, 64'h9999);
      rd(ST1, d);           check("ch1_status", d, 64'h0110_4000_0000_0000);
      rd(ST0, d);           check("ch0_unchanged", d, 64'h0101_0000_0000_0000);

      // error inject and ignored bus cycles
      wr(A_EI, 64'h5);
      check("ei_load", o_errinj, 64'h5);
      raw(bus(1'b1, 1'b1, 1'b0, 1'b1, A_EI, 64'h77));
      check("ei_cfg", o_errinj, 64'h5);
      raw(bus(1'b1, 1'b0, 1'b0, 1'b0, A_EI, 64'h99));
      check("ei_dw0", o_errinj, 64'h5);
      raw(bus(1'b0, 1'b0, 1'b0, 1'b1, A_EI, 64'hAA));
      check("ei_vld0", o_errinj, 64'h5);
      raw(bus(1'b1, 1'b1, 1'b0, 1'b1, A_CTL, 64'h8000_0000_0000_0001));
      wr(ST0, 64'hFFFF_FFFF_FFFF_FFFF);
      rd(ST0, d);           check("ign_writes", d, 64'h0101_0000_0000_0000);
      raw(bus(1'b1, 1'b1, 1'b1, 1'b1, WIN + 24'd3, 64'h0));
      check("cfg_rd_n1", 64'(o_mmio_rd_v), 64'h0);
      tick();
      check("cfg_rd_n2", 64'(o_mmio_rd_v), 64'h0);

      // reset during an outstanding read
      raw(bus(1'b1, 1'b0, 1'b1, 1'b1, WIN + 24'd3, 64'h0));
      reset = 1'b0;
      #1;
      check("mrst_rd_v", 64'(o_mmio_rd_v), 64'h0);
      check("mrst_rd_d", o_mmio_rd_d, 64'h0);
      check("mrst_errinj", o_errinj, 64'h0);
      check("mrst_frozen", 64'(o_frozen), 64'h0);
      tick();
      check("mrst_hold", 64'(o_mmio_rd_v), 64'h0);
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("mrst_no_rsp", 64'(o_mmio_rd_v), 64'h0);
      end
      rd(ST0, d);           check("mrst_st0", d, 64'h0);
      rd(ST1, d);           check("mrst_st1", d, 64'h0);
      check("mrst_errinj2", o_errinj, 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ktms_debug_trace.md
KTMS_DEBUG_TRACE -- requirements
Module: ktms_debug_trace

Interface
REQ-001 Parameters (name, default, meaning):
- regs, 16, number of 64b snapshot registers.
- channels, 2, number of capture channels.
- cr_depth, 16, capture entries per channel (power of 2, >=2).
- mmioaddr, 1, MMIO read window base (dword address).
- mmioaddr_ctl, 2, control register address.
- mmioaddr_err_inj, 3, error-inject register address.
- mmiobus_width, 94, width of i_mmiobus.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- reset, in, 1, asynchronous, active-low.
- i_mmiobus, in, mmiobus_width, {vld,cfg,rnw,dw,addr[0:24],data[0:64]}; the low addr bit and the data parity bit are dropped.
- i_dbg_reg, in, 64*regs, snapshot inputs.
- i_cap_v, in, channels, per-channel capture strobe.
- i_cap_d, in, 128*channels, per-channel capture data {rega,regb}.
- o_mmio_rd_v, out, 1, read response valid.
- o_mmio_rd_d, out, 64, read response data.
- o_errinj, out, 64, error-inject value.
- o_frozen, out, channels, per-channel stopped flag.

Function
REQ-003 A hit SHALL be vld=1, cfg=0, dw=1 and an address in the block's decoded range; all other bus cycles SHALL be ignored.
REQ-004 i_dbg_reg SHALL be registered every cycle without reset; reads return the registered value.
REQ-005 Local read map, dword offset from mmioaddr:
- 0..regs-1: snapshot registers.
- Then per channel c, in order: 1 status word, followed by 2*cr_depth entry words (rega of slot s at 2s, regb at 2s+1).
REQ-006 Status word: bits[0:7] write pointer, bits[8:15] valid count, bits[16:17] state, bits[18:63] zero.
REQ-007 Read latency SHALL be fixed: a hit read (rnw=1) in cycle N yields o_mmio_rd_v=1 for exactly one cycle in N+2.
REQ-008 An out-of-map offset inside the window SHALL return 0.
REQ-009 Each channel SHALL have states IDLE=0, RUN=1, STOP=2.
- IDLE->RUN: control write with the channel enable bit =1.
- RUN->IDLE: enable bit written 0.
- RUN->STOP: stop mode set and count reaches cr_depth.
- STOP->IDLE: clear.
- STOP->RUN: control write with enable=1 and clear=1.
REQ-010 In RUN, i_cap_v[c]=1 SHALL write i_cap_d slot to entry[wrptr].
- wrptr SHALL increment modulo cr_depth (wraps to 0).
- count SHALL saturate at cr_depth.
REQ-011 Captures in IDLE or STOP SHALL be dropped with no state change; o_frozen[c]=1 exactly in STOP.
REQ-012 Control register (write at mmioaddr_ctl):
- bits[0:channels-1]: enable.
- bit 62: mode (0 wrap, 1 stop-when-full).
- bit 63: clear (self-clearing); clear zeroes wrptr and count but not entry contents.
REQ-013 Clear coincident with i_cap_v: clear SHALL win and the capture SHALL be dropped.
REQ-014 Control write coincident with capture: the capture SHALL be processed under the pre-write state; the new state SHALL apply from the next cycle.
REQ-015 Capture on the cycle count reaches cr_depth in stop mode SHALL be stored; state becomes STOP next cycle.
REQ-016 A capture coincident with an MMIO read of the same slot SHALL return the pre-capture entry.
REQ-017 o_errinj SHALL load the write data on a hit write to mmioaddr_err_inj and hold it otherwise.
REQ-018 Writes to read-window addresses SHALL be ignored.

Reset
REQ-019 Async assert (reset=0):
- o_mmio_rd_v=0, o_mmio_rd_d=0, o_errinj=0, o_frozen=0.
- All channels IDLE; wrptr=0, count=0; control register=0.
- Any in-flight read SHALL be discarded with no response after deassert.
REQ-020 Entry storage and snapshot registers need not be reset.
REQ-021 Deassertion SHALL be synchronised to clk.

Verification
REQ-022 Snapshot read: i_dbg_reg word 3 = 0xDEAD_BEEF_0000_0003, read offset 3 -> o_mmio_rd_v at N+2 with that data.
REQ-023 Wrap: ctl=0x8000_0000_0000_0000 (ch0 enable, wrap), 18 captures with rega=k for k=0..17, cr_depth=16 -> status wrptr=2, count=16, state=1; slot 0 rega=16.
REQ-024 Stop mode: enable ch0 with bit62=1, 20 captures -> o_frozen[0]=1 after the 16th, slot 0 rega=0; a clear+enable write returns to RUN with count=0.
REQ-025 Collision: clear and i_cap_v in the same cycle -> count=0, wrptr=0.
REQ-026 Error injection: write 0x5 to mmioaddr_err_inj -> o_errinj=0x5 next cycle; a cfg=1 write leaves it unchanged.
REQ-027 Reset mid-read: reset=0 in cycle N+1 of a read -> no o_mmio_rd_v; all outputs 0.
